// File: rtl/spi_xfer_ctrl_if.sv
// Bus bundle between the APB register file (master side) and spi_xfer_ctrl (slave side).
//
// Request side (driven by the master):
//   start        request one character transfer
//   abort        terminate the transfer in progress
//   divider      half SCLK period minus 1, in pclk cycles
//   char_len     bits per character, 0 means 8
//   lsb          1 = LSB first, 0 = MSB first
//   cpol         SCLK idle level
//   tx_data      character to send
//   miso_pad_i   serial input from the pad
// Result side (driven by the controller):
//   transfer_en  one-cycle launch strobe to the MOSI generator
//   trx          TX shift register, read by the MOSI generator
//   sclk_pad_o   serial clock pad
//   ss_pad_o     slave select pad, active low
//   busy         transfer in progress
//   done         one-cycle completion pulse
//   rx_data      received character, right-aligned
interface spi_xfer_ctrl_if #(
  parameter int unsigned DIV_W = 8
);
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] divider;
  logic [2:0]       char_len;
  logic             lsb;
  logic             cpol;
  logic [7:0]       tx_data;
  logic             miso_pad_i;

  logic             transfer_en;
  logic [7:0]       trx;
  logic             sclk_pad_o;
  logic             ss_pad_o;
  logic             busy;
  logic             done;
  logic [7:0]       rx_data;

  modport master (
    output start, abort, divider, char_len, lsb, cpol, tx_data, miso_pad_i,
    input  transfer_en, trx, sclk_pad_o, ss_pad_o, busy, done, rx_data
  );

  modport slave (
    input  start, abort, divider, char_len, lsb, cpol, tx_data, miso_pad_i,
    output transfer_en, trx, sclk_pad_o, ss_pad_o, busy, done, rx_data
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI character transfer sequencer (1..8 bits per character).
//
// Owns the divided serial clock, slave select, bit counter and TX shift register. Each bit is
// launched by a one-cycle transfer_en strobe; the external MOSI generator captures the pre-shift
// bit of trx on the edge that ends the strobe cycle, and trx shifts on that same edge. MISO is
// sampled on the leading SCLK edge and placed into a right-aligned receive register.
//
// Ports:
//   pclk    system clock, rising edge
//   preset  asynchronous active-high reset
//   bus     spi_xfer_ctrl_if slave modport (request inputs, SCLK/SS/strobe/result outputs)
//
// Cycle budget per character: 1 (setup) + 2*N*(D+1) (lead/trail halves) + (D+1) (ss hold).
// The strobe for bit b>0 is issued in the last trail cycle of bit b-1, so MOSI is stable for the
// whole lead half of bit b, even when D=0.
module spi_xfer_ctrl #(
  parameter int unsigned DIV_W = 8
) (
  input logic            pclk,
  input logic            preset,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLead,
    StTrail,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bits_left_q, bits_left_d;
  logic [3:0]       n_len_q, n_len_d;
  logic             lsb_q, lsb_d;
  logic             cpol_q, cpol_d;
  logic [7:0]       trx_q, trx_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             te_q, te_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_at_div;
  logic             cnt_last_next;
  logic             more_bits;
  logic [3:0]       start_len;
  logic [3:0]       rx_idx;
  logic [7:0]       trx_shifted;

  assign cnt_at_div    = (cnt_q == div_q);
  // True when the following cycle is the final one of the current half period.
  assign cnt_last_next = (({1'b0, cnt_q} + 1'b1) == {1'b0, div_q});
  assign more_bits     = (bits_left_q > 4'd1);
  assign start_len     = (bus.char_len == 3'd0) ? 4'd8 : {1'b0, bus.char_len};
  // bits_left = N-k while receiving bit k.
  assign rx_idx        = lsb_q ? (n_len_q - bits_left_q) : (bits_left_q - 4'd1);
  assign trx_shifted   = lsb_q ? (trx_q >> 1) : (trx_q << 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bits_left_d = bits_left_q;
    n_len_d     = n_len_q;
    lsb_d       = lsb_q;
    cpol_d      = cpol_q;
    trx_d       = trx_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    te_d        = 1'b0;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // The MOSI generator has taken the pre-shift bit on this edge.
    if (te_q) begin
      trx_d = trx_shifted;
    end

    unique case (state_q)
      StIdle: begin
        ss_d   = 1'b1;
        sclk_d = bus.cpol;
        busy_d = 1'b0;
        if (bus.start) begin
          div_d       = bus.divider;
          n_len_d     = start_len;
          bits_left_d = start_len;
          lsb_d       = bus.lsb;
          cpol_d      = bus.cpol;
          trx_d       = bus.tx_data;
          rx_sr_d     = 8'h00;
          cnt_d       = '0;
          ss_d        = 1'b0;
          busy_d      = 1'b1;
          te_d        = 1'b1;
          state_d     = StSetup;
        end
      end

      StSetup: begin
        cnt_d   = '0;
        state_d = StLead;
      end

      StLead: begin
        if (cnt_at_div) begin
          sclk_d          = ~cpol_q;
          rx_sr_d[rx_idx[2:0]] = bus.miso_pad_i;
          cnt_d           = '0;
          state_d         = StTrail;
          // With D=0 the trail half is a single cycle, so the next strobe starts right away.
          te_d            = more_bits && (div_q == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StTrail: begin
        te_d = more_bits && cnt_last_next;
        if (cnt_at_div) begin
          sclk_d = cpol_q;
          cnt_d  = '0;
          if (more_bits) begin
            bits_left_d = bits_left_q - 4'd1;
            state_d     = StLead;
          end else begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        if (cnt_at_div) begin
          ss_d      = 1'b1;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort only matters outside IDLE, so start wins when both arrive in IDLE.
    if (bus.abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      ss_d      = 1'b1;
      sclk_d    = cpol_q;
      te_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      cnt_d     = '0;
      rx_data_d = rx_data_q;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= '0;
      bits_left_q <= 4'd0;
      n_len_q     <= 4'd0;
      lsb_q       <= 1'b0;
      cpol_q      <= 1'b0;
      trx_q       <= 8'h00;
      rx_sr_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      te_q        <= 1'b0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bits_left_q <= bits_left_d;
      n_len_q     <= n_len_d;
      lsb_q       <= lsb_d;
      cpol_q      <= cpol_d;
      trx_q       <= trx_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      te_q        <= te_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.transfer_en = te_q;
  assign bus.trx         = trx_q;
  assign bus.sclk_pad_o  = sclk_q;
  assign bus.ss_pad_o    = ss_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a timeline model (cycle offset within a transfer plus closed-form
// waveform rules) checked every cycle, plus directed literal expectations per scenario.
module tb_spi_xfer_ctrl;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  spi_xfer_ctrl_if #(.DIV_W(8)) bus ();

  spi_xfer_ctrl #(.DIV_W(8)) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // MOSI generator and loopback
  logic   loopback = 1'b1;
  logic   miso_fix = 1'b0;
  logic   mosi_q   = 1'b0;
  int     cfg_n    = 8;
  logic   cfg_lsb  = 1'b0;
  logic   mosi_log[$];

  always @(posedge pclk) begin
    if (bus.transfer_en) begin
      mosi_q <= cfg_lsb ? bus.trx[0] : bus.trx[cfg_n-1];
      mosi_log.push_back(cfg_lsb ? bus.trx[0] : bus.trx[cfg_n-1]);
    end
  end

  assign bus.miso_pad_i = loopback ? mosi_q : miso_fix;

  // Timeline model: m_o is the offset of the current cycle inside an active transfer.
  logic       m_act       = 1'b0;
  int         m_o         = 0;
  int         m_d         = 0;
  int         m_n         = 8;
  int         m_t         = 0;
  logic       m_lsb       = 1'b0;
  logic       m_cpol      = 1'b0;
  logic [7:0] m_tx        = 8'h00;
  logic [7:0] m_acc       = 8'h00;
  logic [7:0] m_rx        = 8'h00;
  logic       m_done      = 1'b0;
  logic       m_idle_sclk = 1'b0;
  int         m_k;

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_act       = 1'b0;
      m_o         = 0;
      m_rx        = 8'h00;
      m_done      = 1'b0;
      m_idle_sclk = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_act) begin
        if (bus.abort) begin
          m_act       = 1'b0;
          m_idle_sclk = m_cpol;
        end else begin
          // Leading edge of bit k ends cycle (2k+1)*(D+1).
          if (m_o > 0 && (m_o % (m_d + 1)) == 0 && ((m_o / (m_d + 1)) % 2) == 1) begin
            m_k = (m_o / (m_d + 1)) / 2;
            if (m_k < m_n) m_acc[m_lsb ? m_k : (m_n - 1 - m_k)] = bus.miso_pad_i;
          end
          if (m_o == m_t - 1) begin
            m_act       = 1'b0;
            m_done      = 1'b1;
            m_rx        = m_acc;
            m_idle_sclk = m_cpol;
          end else begin
            m_o++;
          end
        end
      end else begin
        m_idle_sclk = bus.cpol;
        if (bus.start) begin
          m_d    = int'(bus.divider);
          m_n    = (bus.char_len == 3'd0) ? 8 : int'(bus.char_len);
          m_lsb  = bus.lsb;
          m_cpol = bus.cpol;
          m_tx   = bus.tx_data;
          m_t    = 1 + 2 * m_n * (m_d + 1) + (m_d + 1);
          m_acc  = 8'h00;
          m_act  = 1'b1;
          m_o    = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  logic chk_en = 1'b0;
  logic e_busy, e_ss, e_te, e_sclk, e_done, g_bit, e_bit;
  int   per, bidx;

  always @(negedge pclk) begin
    if (chk_en) begin
      if (m_act) begin
        per    = m_d + 1;
        e_busy = 1'b1;
        e_ss   = 1'b0;
        e_done = 1'b0;
        e_te   = ((m_o % (2 * per)) == 0) && ((m_o / (2 * per)) < m_n);
        if (m_o >= 1 && m_o < 1 + 2 * m_n * per) e_sclk = m_cpol ^ (((m_o - 1) / per) % 2 == 1);
        else                                      e_sclk = m_cpol;
      end else begin
        e_busy = 1'b0;
        e_ss   = 1'b1;
        e_done = m_done;
        e_te   = 1'b0;
        e_sclk = m_idle_sclk;
      end
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("ss", 32'(bus.ss_pad_o), 32'(e_ss));
      check("transfer_en", 32'(bus.transfer_en), 32'(e_te));
      check("sclk", 32'(bus.sclk_pad_o), 32'(e_sclk));
      check("done", 32'(bus.done), 32'(e_done));
      check("rx_data", 32'(bus.rx_data), 32'(m_rx));
      if (e_te && bus.transfer_en) begin
        bidx  = m_o / (2 * per);
        g_bit = m_lsb ? bus.trx[0] : bus.trx[m_n-1];
        e_bit = m_lsb ? m_tx[bidx] : m_tx[m_n-1-bidx];
        check("mosi_bit", 32'(g_bit), 32'(e_bit));
      end
    end
  end

  // Event counters for the directed scenarios.
  int   busy_cnt, te_cnt, rise_cnt, fall_cnt, done_cnt;
  logic sclk_prev = 1'b0;

  always @(negedge pclk) begin
    busy_cnt += int'(bus.busy);
    te_cnt   += int'(bus.transfer_en);
    done_cnt += int'(bus.done);
    if (bus.sclk_pad_o && !sclk_prev) rise_cnt++;
    if (!bus.sclk_pad_o && sclk_prev) fall_cnt++;
    sclk_prev = bus.sclk_pad_o;
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    te_cnt   = 0;
    rise_cnt = 0;
    fall_cnt = 0;
    done_cnt = 0;
    mosi_log.delete();
  endtask

  task automatic set_cfg(input int d, input int cl, input logic l, input logic cp,
                         input logic [7:0] tx);
    bus.divider  = 8'(d);
    bus.char_len = 3'(cl);
    bus.lsb      = l;
    bus.cpol     = cp;
    bus.tx_data  = tx;
    cfg_n        = (cl == 0) ? 8 : cl;
    cfg_lsb      = l;
  endtask

  // Pulses start for one cycle; returns at the SETUP cycle.
  task automatic launch(input int d, input int cl, input logic l, input logic cp,
                        input logic [7:0] tx);
    set_cfg(d, cl, l, cp, tx);
    clear_counts();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Returns in the done cycle, or flags a failed comparison on timeout.
  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.divider  = 8'd0;
    bus.char_len = 3'd0;
    bus.lsb      = 1'b0;
    bus.cpol     = 1'b0;
    bus.tx_data  = 8'h00;
    clear_counts();
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ss", 32'(bus.ss_pad_o), 32'd1);
    check("rst_sclk", 32'(bus.sclk_pad_o), 32'd0);
    check("rst_te", 32'(bus.transfer_en), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_trx", 32'(bus.trx), 32'd0);
    check("rst_rx", 32'(bus.rx_data), 32'd0);
    preset = 1'b0;
    chk_en = 1'b1;
    repeat (2) step();

    // 1: D=1, 8 bits, MSB first, cpol=0, loopback
    loopback = 1'b1;
    launch(1, 0, 1'b0, 1'b0, 8'hA5);
    wait_done("t1_done_timeout");
    check("t1_rx", 32'(bus.rx_data), 32'hA5);
    step();
    check("t1_busy_cycles", 32'(busy_cnt), 32'd35);
    check("t1_pulses", 32'(te_cnt), 32'd8);
    check("t1_rises", 32'(rise_cnt), 32'd8);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    step();

    // 2: D=0, 5 bits, LSB first, loopback
    launch(0, 5, 1'b1, 1'b0, 8'h13);
    wait_done("t2_done_timeout");
    check("t2_rx", 32'(bus.rx_data), 32'h13);
    step();
    check("t2_busy_cycles", 32'(busy_cnt), 32'd12);
    check("t2_pulses", 32'(te_cnt), 32'd5);
    check("t2_mosi_len", 32'(mosi_log.size()), 32'd5);
    if (mosi_log.size() == 5) begin
      check("t2_mosi0", 32'(mosi_log[0]), 32'd1);
      check("t2_mosi1", 32'(mosi_log[1]), 32'd1);
      check("t2_mosi2", 32'(mosi_log[2]), 32'd0);
      check("t2_mosi3", 32'(mosi_log[3]), 32'd0);
      check("t2_mosi4", 32'(mosi_log[4]), 32'd1);
    end

    // 3: cpol=1, D=2, 3 bits, MISO held high
    loopback = 1'b0;
    miso_fix = 1'b1;
    bus.cpol = 1'b1;
    repeat (2) step();
    check("t3_sclk_idle", 32'(bus.sclk_pad_o), 32'd1);
    launch(2, 3, 1'b0, 1'b1, 8'h05);
    repeat (3) step();
    check("t3_sclk_before_edge", 32'(bus.sclk_pad_o), 32'd1);
    step();
    check("t3_sclk_first_fall", 32'(bus.sclk_pad_o), 32'd0);
    wait_done("t3_done_timeout");
    check("t3_rx", 32'(bus.rx_data), 32'h07);
    bus.cpol = 1'b0;
    loopback = 1'b1;
    repeat (2) step();

    // 4: start while busy ignored; start in the done cycle accepted
    launch(1, 4, 1'b0, 1'b0, 8'h09);
    repeat (3) step();
    set_cfg(5, 2, 1'b1, 1'b0, 8'hFF);
    cfg_n     = 4;
    cfg_lsb   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("t4a_done_timeout");
    check("t4a_rx", 32'(bus.rx_data), 32'h09);
    check("t4a_busy_cycles", 32'(busy_cnt), 32'd19);
    check("t4a_pulses", 32'(te_cnt), 32'd4);
    check("t4_ss_high_done", 32'(bus.ss_pad_o), 32'd1);
    set_cfg(1, 4, 1'b0, 1'b0, 8'h06);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t4b_ss_low", 32'(bus.ss_pad_o), 32'd0);
    check("t4b_busy", 32'(bus.busy), 32'd1);
    wait_done("t4b_done_timeout");
    check("t4b_rx", 32'(bus.rx_data), 32'h06);
    repeat (2) step();

    // 5: abort after the third strobe
    launch(1, 0, 1'b0, 1'b0, 8'h3C);
    for (int i = 0; i < 200 && te_cnt < 3; i++) step();
    check("t5_reached_third", 32'(te_cnt), 32'd3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t5_ss", 32'(bus.ss_pad_o), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_te", 32'(bus.transfer_en), 32'd0);
    check("t5_sclk", 32'(bus.sclk_pad_o), 32'd0);
    repeat (5) step();
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_rx_held", 32'(bus.rx_data), 32'h06);
    check("t5_no_more_pulses", 32'(te_cnt), 32'd3);

    // 6: reset mid-bit, then a normal transfer
    launch(3, 6, 1'b1, 1'b0, 8'h2B);
    repeat (10) step();
    #2;
    preset = 1'b1;
    #1;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_ss", 32'(bus.ss_pad_o), 32'd1);
    check("t6_sclk", 32'(bus.sclk_pad_o), 32'd0);
    check("t6_te", 32'(bus.transfer_en), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_trx", 32'(bus.trx), 32'd0);
    check("t6_rx", 32'(bus.rx_data), 32'd0);
    step();
    preset = 1'b0;
    repeat (2) step();
    launch(0, 0, 1'b0, 1'b0, 8'h5A);
    wait_done("t6_done_timeout");
    check("t6_rx_after", 32'(bus.rx_data), 32'h5A);
    check("t6_busy_cycles", 32'(busy_cnt), 32'd18);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
